fifo_burst_reader: RTL and testbench
====================================

FIFO_BURST_READER -- requirements
Module: fifo_burst_reader

Interface
REQ-001 Parameter dw, default 8: data word width in bits.
REQ-002 Parameter aw, default 4: address width of the attached short FIFO, which has a depth of 2**aw.
REQ-003 Parameter burst, default 4: maximum words per burst; legal range is 1 to 2**aw-1.
REQ-004 Parameter timeout, default 16: number of idle cycles with a non-empty FIFO before a partial burst is forced; legal range is at least 1.
REQ-005 clk  input  1  single clock; all logic is on the rising edge.
REQ-006 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-007 fifo_dout  input  dw  FIFO head word, valid combinationally whenever fifo_empty=0.
REQ-008 fifo_empty  input  1  FIFO empty flag.
REQ-009 fifo_count  input  aw  FIFO count encoding: all-ones means empty, otherwise occupancy-1.
REQ-010 fifo_re  output  1  pop strobe to the FIFO; the head advances on the clock edge where it is 1.
REQ-011 out_data  output  dw  registered stream data.
REQ-012 out_valid  output  1  stream valid.
REQ-013 out_ready  input  1  stream ready from the sink.
REQ-014 out_first  output  1  marks the first beat of a burst; qualified by out_valid.
REQ-015 out_last  output  1  marks the last beat of a burst; qualified by out_valid.
REQ-016 busy  output  1  high while the state is BURST.

Function
REQ-017 Occupancy occ = fifo_count+1, computed modulo 2**aw (so all-ones maps to 0).
REQ-018 There SHALL be two states, IDLE and BURST.
REQ-019 In IDLE, the idle timer increments each cycle fifo_empty=0 and clears to 0 on any cycle fifo_empty=1; it saturates at timeout.
REQ-020 The trigger in IDLE is occ>=burst, or (fifo_empty=0 and timer==timeout-1).
REQ-021 On trigger: capture n = min(occ, burst) into the remaining counter, go to BURST, and clear the timer.
- Same cycle: assert fifo_re, and load fifo_dout into out_data with out_first=1.
REQ-022 The load condition is (out_valid=0 or out_ready=1), remaining>0, and fifo_empty=0.
- fifo_re equals the load condition in BURST, and equals the trigger in IDLE.
REQ-023 fifo_re SHALL never be 1 while fifo_empty=1.
REQ-024 Each load registers fifo_dout into out_data, sets out_valid=1 on the next edge, and decrements remaining.
- out_last is set when the loaded word is the one that brings remaining to 0.
REQ-025 out_valid=1 with out_ready=0 holds out_data, out_first and out_last stable.
REQ-026 out_valid=1 with out_ready=1 and no load in the same cycle clears out_valid on the next edge.
REQ-027 Throughput is one word per cycle with out_ready held at 1; there are no bubbles within a burst.
REQ-028 Latency is one cycle from the trigger cycle to the first out_valid.
REQ-029 Leave BURST for IDLE on the edge where the out_last beat is accepted (out_valid & out_ready & out_last).
- A new trigger is evaluated from the following cycle onward.
REQ-030 Writes to the FIFO during BURST are permitted and do not change n.
- n words are always available, because occupancy cannot decrease except by this block's own pops.
REQ-031 Exactly n beats per burst, with out_first on beat 1 and out_last on beat n.
- When n=1, the single beat carries both out_first and out_last.
REQ-032 Counters are sized ceil(log2(burst+1)) and ceil(log2(timeout+1)) bits; there is no wrap.

Reset
REQ-033 While rst_n=0, independent of clk:
- state is IDLE;
- out_valid, out_first, out_last, busy and fifo_re are 0;
- out_data, timer and remaining are 0.
REQ-034 Reset does not touch the FIFO.
- Words not yet popped remain and are treated as new data after release.
- A word already registered in out_data is discarded.
REQ-035 The first trigger evaluation occurs on the first rising edge after rst_n deasserts.

Verification
REQ-036 Full burst. Stimulus: dw=8, aw=4, burst=4, timeout=16; write 0x11,0x12,0x13,0x14 back-to-back; out_ready=1.
- Required response: 4 consecutive beats 0x11..0x14 with out_first on 0x11 and out_last on 0x14.
- The FIFO is empty afterwards and busy=0 on the cycle after the last beat.
REQ-037 Timeout flush. Stimulus: write 0xA0,0xA1 only.
- Required response: no out_valid for the first 15 non-empty cycles.
- Then a 2-beat burst, with out_first on 0xA0 and out_last on 0xA1.
REQ-038 Backpressure. Stimulus: 4 words queued; out_ready pattern 1,0,0,1,0,1,1.
- Required response: out_data is stable during stalls, and exactly 0x11..0x14 appear in order with no duplicates.
- fifo_re is never 1 while fifo_empty=1.
REQ-039 Multiple bursts. Stimulus: 10 words 0x00..0x09.
- Required response: bursts 0x00-0x03 and 0x04-0x07 run back-to-back.
- Then 0x08-0x09 follows after the timeout, with out_last on 0x03, 0x07 and 0x09.
REQ-040 Reset mid-burst. Stimulus: assert rst_n=0 after beat 0x12 is accepted.
- Required response: out_valid=0 immediately.
- After release, the remaining words start a new burst with out_first on the current FIFO head.
REQ-041 Concurrent write. Stimulus: 4 words queued; during the burst write 0x55.
- Required response: the burst is exactly 4 beats; 0x55 is emitted alone after the timeout with out_first=out_last=1.

Source files
------------

// File: rtl/fifo_burst_reader_if.sv
// Bundle between fifo_burst_reader, the short FIFO it drains and the stream sink.
// The master modport is the reader side; slave is the FIFO/sink side.
interface fifo_burst_reader_if #(
    parameter int dw = 8,
    parameter int aw = 4
);
    logic [dw-1:0] fifo_dout;
    logic          fifo_empty;
    logic [aw-1:0] fifo_count;
    logic          fifo_re;
    logic [dw-1:0] out_data;
    logic          out_valid;
    logic          out_ready;
    logic          out_first;
    logic          out_last;
    logic          busy;

    modport master (
        input  fifo_dout, fifo_empty, fifo_count, out_ready,
        output fifo_re, out_data, out_valid, out_first, out_last, busy
    );

    modport slave (
        output fifo_dout, fifo_empty, fifo_count, out_ready,
        input  fifo_re, out_data, out_valid, out_first, out_last, busy
    );
endinterface

// File: rtl/fifo_burst_reader.sv
// Drains a short FIFO into a ready/valid stream in bursts of up to `burst` words,
// flushing a partial burst once the FIFO has sat non-empty for `timeout` cycles.
module fifo_burst_reader #(
    parameter int dw      = 8,
    parameter int aw      = 4,
    parameter int burst   = 4,
    parameter int timeout = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    fifo_burst_reader_if.master bus
);
    localparam int rw = $clog2(burst + 1);
    localparam int tw = $clog2(timeout + 1);

    localparam logic [aw:0]   BURST_OCC = (aw + 1)'(burst);
    localparam logic [rw-1:0] BURST_N   = rw'(burst);
    localparam logic [tw-1:0] TMAX      = tw'(timeout);
    localparam logic [tw-1:0] TFIRE     = tw'(timeout - 1);

    typedef enum logic {IDLE, BURST} state_t;

    state_t        state, state_nx;
    logic [aw-1:0] occ;
    logic [tw-1:0] timer;
    logic [rw-1:0] remaining;
    logic [rw-1:0] n;
    logic          full_hit;
    logic          trigger;
    logic          load;
    logic          accept;

    logic [dw-1:0] data_q;
    logic          valid_q;
    logic          first_q;
    logic          last_q;

    always_comb begin
        // all-ones count wraps to occupancy 0
        occ      = bus.fifo_count + aw'(1);
        full_hit = ({1'b0, occ} >= BURST_OCC);
        n        = full_hit ? BURST_N : rw'(occ);
        trigger  = (state == IDLE) && !bus.fifo_empty && (full_hit || (timer == TFIRE));
        accept   = valid_q && bus.out_ready;
        load     = (state == IDLE) ? trigger
                 : ((!valid_q || bus.out_ready) && (remaining != '0) && !bus.fifo_empty);
        state_nx = state;
        case (state)
            IDLE:    if (trigger) state_nx = BURST;
            BURST:   if (accept && last_q) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            timer     <= '0;
            remaining <= '0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            first_q   <= 1'b0;
            last_q    <= 1'b0;
        end else begin
            state <= state_nx;

            if (state == BURST || trigger || bus.fifo_empty) begin
                timer <= '0;
            end else if (timer != TMAX) begin
                timer <= timer + tw'(1);
            end

            if (load) begin
                data_q  <= bus.fifo_dout;
                valid_q <= 1'b1;
                if (state == IDLE) begin
                    first_q   <= 1'b1;
                    last_q    <= (n == rw'(1));
                    remaining <= n - rw'(1);
                end else begin
                    first_q   <= 1'b0;
                    last_q    <= (remaining == rw'(1));
                    remaining <= remaining - rw'(1);
                end
            end else if (accept) begin
                valid_q <= 1'b0;
            end
        end
    end

    // Masked by rst_n so a full FIFO is never popped while reset is held.
    assign bus.fifo_re   = load && rst_n;
    assign bus.out_data  = data_q;
    assign bus.out_valid = valid_q;
    assign bus.out_first = first_q;
    assign bus.out_last  = last_q;
    assign bus.busy      = (state == BURST);
endmodule

// File: tb/tb_fifo_burst_reader.sv
// Bench for fifo_burst_reader: behavioural FIFO, burst-partition reference model,
// directed scenarios plus randomized data/backpressure rounds.
module tb_fifo_burst_reader;
    localparam int DW      = 8;
    localparam int AW      = 4;
    localparam int BURST   = 4;
    localparam int TIMEOUT = 16;

    typedef struct packed {
        logic [7:0] d;
        logic       f;
        logic       l;
    } beat_t;

    logic clk = 1'b0;
    logic rst_n;

    fifo_burst_reader_if #(.dw(DW), .aw(AW)) bus ();

    fifo_burst_reader #(
        .dw(DW), .aw(AW), .burst(BURST), .timeout(TIMEOUT)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    // Behavioural FIFO: depth 16, count encoded as occupancy-1 (all-ones when empty).
    logic [7:0] fmem [16];
    logic [3:0] rp   = '0;
    logic [3:0] wp   = '0;
    logic [4:0] focc = '0;
    logic       wr_en;
    logic [7:0] wr_data;
    bit         re_viol   = 1'b0;
    bit         re_in_rst = 1'b0;
    int         cyc       = 0;

    assign bus.fifo_empty = (focc == 5'd0);
    assign bus.fifo_count = 4'(focc - 5'd1);
    assign bus.fifo_dout  = fmem[rp];

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (bus.fifo_re && focc == 5'd0) re_viol <= 1'b1;
        if (bus.fifo_re && !rst_n) re_in_rst <= 1'b1;
        if (wr_en) begin
            fmem[wp] <= wr_data;
            wp       <= wp + 4'd1;
        end
        if (bus.fifo_re && focc != 5'd0) rp <= rp + 4'd1;
        focc <= focc + (wr_en ? 5'd1 : 5'd0) - ((bus.fifo_re && focc != 5'd0) ? 5'd1 : 5'd0);
    end

    int ncmp  = 0;
    int nfail = 0;

    logic [7:0] wq   [$];
    logic [7:0] pend [$];
    beat_t      expq [$];
    int         first_t [$];
    int         last_t  [$];
    int         first_valid_t;
    int         wr_first_t;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        ncmp++;
        assert (got === exp)
        else begin
            nfail++;
            $error("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Words written one per cycle while draining
    task automatic queue_words(input int n, input logic [7:0] base);
        for (int i = 0; i < n; i++) begin
            pend.push_back(base + 8'(i));
            wq.push_back(base + 8'(i));
        end
    endtask

    // Words written straight into the FIFO, e.g. while the reader is held in reset
    task automatic fill_words(input int n, input bit rnd, input logic [7:0] base);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            wr_en   = 1'b1;
            wr_data = rnd ? 8'($urandom) : base + 8'(i);
            wq.push_back(wr_data);
        end
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    // Reference: FIFO order cut into consecutive chunks of min(left, BURST)
    task automatic plan();
        int    n;
        beat_t e;
        while (wq.size() != 0) begin
            n = (wq.size() < BURST) ? wq.size() : BURST;
            for (int i = 0; i < n; i++) begin
                e.d = wq.pop_front();
                e.f = (i == 0);
                e.l = (i == n - 1);
                expq.push_back(e);
            end
        end
    endtask

    // mode 0: ready always 1; mode 1: fixed ready pattern on valid cycles; mode 2: random ready
    task automatic drain(input int mode, input int budget, input bit inject);
        int         pat [7] = '{1, 0, 0, 1, 0, 1, 1};
        int         pi = 0;
        int         k = 0;
        bit         injected = 1'b0;
        bit         pstall = 1'b0;
        logic       v, f, l, r;
        logic [7:0] d, pd;
        logic       pf, pl;
        beat_t      e;
        pd = '0; pf = 1'b0; pl = 1'b0;
        first_t.delete();
        last_t.delete();
        first_valid_t = -1;
        wr_first_t    = -1;
        while ((expq.size() != 0 || pend.size() != 0) && k < budget) begin
            @(negedge clk);
            k++;
            wr_en = 1'b0;
            if (pend.size() != 0) begin
                if (wr_first_t < 0) wr_first_t = cyc + 1;
                wr_en   = 1'b1;
                wr_data = pend.pop_front();
            end
            v = bus.out_valid;
            d = bus.out_data;
            f = bus.out_first;
            l = bus.out_last;
            if (pstall) begin
                check("stall_valid", 32'(v), 32'd1);
                check("stall_data", 32'(d), 32'(pd));
                check("stall_flags", {30'd0, f, l}, {30'd0, pf, pl});
            end
            if (v && first_valid_t < 0) first_valid_t = cyc;
            case (mode)
                1:       r = (v && pi < 7) ? pat[pi][0] : 1'b1;
                2:       r = ($urandom_range(0, 3) != 0);
                default: r = 1'b1;
            endcase
            if (mode == 1 && v) pi++;
            if (inject && !injected && v) begin
                pend.push_back(8'h55);
                injected = 1'b1;
            end
            bus.out_ready = r;
            if (v && r) begin
                if (expq.size() == 0) begin
                    check("extra_beat", 32'(d), 32'hFFFF_FFFF);
                end else begin
                    e = expq.pop_front();
                    check("beat_data", 32'(d), 32'(e.d));
                    check("beat_first", 32'(f), 32'(e.f));
                    check("beat_last", 32'(l), 32'(e.l));
                    if (e.f) first_t.push_back(cyc);
                    if (e.l) last_t.push_back(cyc);
                end
            end
            pstall = v && !r;
            pd = d; pf = f; pl = l;
        end
        check("drain_left", 32'(expq.size()), 32'd0);
        @(negedge clk);
        wr_en = 1'b0;
        bus.out_ready = 1'b1;
        check("idle_busy", 32'(bus.busy), 32'd0);
        check("idle_valid", 32'(bus.out_valid), 32'd0);
    endtask

    initial begin
        int    rel;
        int    kw;
        bit    found;
        beat_t eb;

        rst_n         = 1'b0;
        wr_en         = 1'b0;
        wr_data       = '0;
        bus.out_ready = 1'b1;

        repeat (3) @(negedge clk);
        check("rst_valid", 32'(bus.out_valid), 32'd0);
        check("rst_flags", {30'd0, bus.out_first, bus.out_last}, 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_re", 32'(bus.fifo_re), 32'd0);
        check("rst_data", 32'(bus.out_data), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Full burst, no bubbles, FIFO empty and idle afterwards
        queue_words(4, 8'h11);
        plan();
        drain(0, 200, 1'b0);
        check("s1_bursts", 32'(first_t.size()), 32'd1);
        if (first_t.size() == 1 && last_t.size() == 1)
            check("s1_span", 32'(last_t[0] - first_t[0]), 32'd3);
        check("s1_empty", 32'(bus.fifo_empty), 32'd1);

        // Timeout flush of a partial burst
        queue_words(2, 8'hA0);
        plan();
        drain(0, 200, 1'b0);
        check("s2_flush_delay", 32'(first_valid_t - wr_first_t), 32'(TIMEOUT));

        // Backpressure with a fixed ready pattern
        queue_words(4, 8'h11);
        plan();
        drain(1, 200, 1'b0);

        // Ten words: two full bursts back-to-back, then a timed-out pair
        queue_words(10, 8'h00);
        plan();
        drain(0, 300, 1'b0);
        check("s4_bursts", 32'(first_t.size()), 32'd3);
        if (first_t.size() == 3 && last_t.size() == 3) begin
            check("s4_gap12", 32'(first_t[1] - last_t[0]), 32'd2);
            check("s4_gap23", 32'(first_t[2] - last_t[1]), 32'(TIMEOUT + 1));
        end

        // Concurrent write during a burst does not extend it
        queue_words(4, 8'h11);
        plan();
        eb.d = 8'h55; eb.f = 1'b1; eb.l = 1'b1;
        expq.push_back(eb);
        drain(0, 200, 1'b1);
        check("s6_bursts", 32'(first_t.size()), 32'd2);

        // Reset mid-burst: 0x13 is already in out_data and is lost, 0x14 stays queued
        @(negedge clk);
        rst_n = 1'b0;
        fill_words(4, 1'b0, 8'h11);
        wq.delete();
        @(negedge clk);
        rst_n = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clk);
            if (bus.out_valid && bus.out_data == 8'h12) found = 1'b1;
        end
        check("s5_seen12", 32'(found), 32'd1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("s5_rst_valid", 32'(bus.out_valid), 32'd0);
        check("s5_rst_busy", 32'(bus.busy), 32'd0);
        check("s5_fifo_left", 32'(focc), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        rel = cyc;
        eb.d = 8'h14; eb.f = 1'b1; eb.l = 1'b1;
        expq.push_back(eb);
        drain(0, 100, 1'b0);
        check("s5_restart_delay", 32'(first_valid_t - rel), 32'(TIMEOUT));

        // Random rounds: FIFO preloaded under reset, random data and backpressure
        for (int rnd = 0; rnd < 4; rnd++) begin
            kw = $urandom_range(1, 15);
            @(negedge clk);
            rst_n = 1'b0;
            fill_words(kw, 1'b1, 8'h00);
            @(negedge clk);
            rst_n = 1'b1;
            rel = cyc;
            plan();
            drain(2, 800, 1'b0);
            check("rnd_start_delay", 32'(first_valid_t - rel),
                  (kw >= BURST) ? 32'd1 : 32'(TIMEOUT));
            check("rnd_bursts", 32'(first_t.size()), 32'((kw + BURST - 1) / BURST));
        end

        check("re_when_empty", 32'(re_viol), 32'd0);
        check("re_in_reset", 32'(re_in_rst), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end
endmodule
